// File: rtl/cache_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32i_types : shared types for the I/D cache-to-memory arbiter       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    TURN    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage
`default_nettype wire

// File: rtl/cache_arbiter_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_picker : stateless round-robin choice between I and D requesters  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_picker
  import rv32i_types::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_t last_grant,
  output grant_t grant
);

  // On a tie the side that did not win last time goes next.
  always_comb begin
    grant = GRANT_I;
    if (req_i && req_d) begin
      grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (req_d) begin
      grant = GRANT_D;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_arbiter : shares one physical-memory port between I and D miss |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t            state_q, state_d;
  grant_t                last_grant_q, last_grant_d;
  grant_t                grant;
  logic                  write_q, write_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic                  req_i, req_d;
  logic                  serving;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

  rr_picker u_rr_picker (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Requests are only looked at in IDLE; once granted the holding
  // registers alone define the memory transaction.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_hold;
    write_d      = write_q;
    wdata_d      = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_i || req_d) begin
          last_grant_d = grant;
          if (grant == GRANT_I) begin
            state_d = SERVE_I;
            addr_d  = i_address;
            write_d = 1'b0;
            wdata_d = '0;
          end else begin
            state_d = SERVE_D;
            addr_d  = d_address;
            write_d = d_write;  // read+write together resolves to a write
            wdata_d = d_wdata;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d = TURN;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      write_q      <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
    end
  end

  generate
    if (ADDR_WIDTH == 32) begin : g_addr_word
      rv32i_word addr_q;
      always_ff @(posedge clk) begin
        if (rst) addr_q <= '0;
        else     addr_q <= addr_d;
      end
      assign addr_hold = addr_q;
    end else begin : g_addr_generic
      logic [ADDR_WIDTH-1:0] addr_q;
      always_ff @(posedge clk) begin
        if (rst) addr_q <= '0;
        else     addr_q <= addr_d;
      end
      assign addr_hold = addr_q;
    end
  endgenerate

  assign serving      = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign pmem_read    = serving && !write_q;
  assign pmem_write   = serving && write_q;
  assign pmem_address = serving ? addr_hold : '0;
  assign pmem_wdata   = serving ? wdata_q : '0;

  assign i_resp  = (state_q == SERVE_I) && pmem_resp;
  assign d_resp  = (state_q == SERVE_D) && pmem_resp;
  assign i_rdata = i_resp ? pmem_rdata : '0;
  assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule
`default_nettype wire
